// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, feeds the
// asynchronous instruction memory and fills the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 116,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic [31:0] imem_instruction,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 32'd4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] plus4_q, plus4_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] pc_plus4_s;

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state selection, highest priority first: redirect, stall, halt, range, fetch.
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        plus4_d  = plus4_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (redirect) begin
            pc_d     = redirect_target & 32'hFFFF_FFFC;
            instr_d  = NOP_INSTR;
            plus4_d  = 32'h0000_0000;
            valid_d  = 1'b0;
            halted_d = 1'b0;
        end else if (stall) begin
            pc_d     = pc_q;
            instr_d  = instr_q;
            plus4_d  = plus4_q;
            valid_d  = valid_q;
            halted_d = halted_q;
        end else if (halted_q) begin
            pc_d     = pc_q;
            instr_d  = NOP_INSTR;
            plus4_d  = 32'h0000_0000;
            valid_d  = 1'b0;
            halted_d = 1'b1;
        end else if (pc_q > LAST_PC) begin
            // Fetch fell off the end of memory: the memory word is meaningless here.
            pc_d     = pc_q;
            instr_d  = NOP_INSTR;
            plus4_d  = 32'h0000_0000;
            valid_d  = 1'b0;
            halted_d = 1'b1;
        end else begin
            pc_d     = pc_plus4_s;
            instr_d  = imem_instruction;
            plus4_d  = pc_plus4_s;
            valid_d  = 1'b1;
            halted_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            plus4_q  <= 32'h0000_0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            plus4_q  <= plus4_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = plus4_q;
    assign if_id_valid       = valid_q;
    assign halted            = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free run, stall, redirect, end-of-memory
// halt and reset overriding stall/halt, against hand-computed values.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_instruction;
    logic [31:0] pc;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        halted;

    int n_checks;
    int n_errors;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (116),
        .NOP_INSTR  (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .imem_instruction  (imem_instruction),
        .pc                (pc),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0)      return 32'h2001_0005;
        else if (a == 32'd4) return 32'h2002_0003;
        else                 return {16'h2400, a[15:0]};
    endfunction

    // Asynchronous instruction memory model; out-of-range reads return garbage.
    assign imem_instruction = (pc <= 32'd112) ? mem_word(pc) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                            input logic [31:0] e_p4, input logic e_v, input logic e_h);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".ins"}, if_id_instruction, e_ins);
        check({tag, ".p4"}, if_id_pc_plus4, e_p4);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_v});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, e_h});
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        reset           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0000_0000;

        // T1: reset then first fetch
        step();
        step();
        check_if("rst", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_if("t1", 32'd4, 32'h2001_0005, 32'd4, 1'b1, 1'b0);

        // T2: free run
        step();
        check_if("t2", 32'd8, 32'h2002_0003, 32'd8, 1'b1, 1'b0);

        // T3: stall at pc=8 for three edges
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if("t3.stall", 32'd8, 32'h2002_0003, 32'd8, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step();
        check_if("t3.rel", 32'd12, 32'h2400_0008, 32'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_if("t2.run", 32'd16 + 32'(4 * i), 32'h2400_0000 | (32'd12 + 32'(4 * i)),
                     32'd16 + 32'(4 * i), 1'b1, 1'b0);
        end

        // T4: redirect with stall, unaligned target
        redirect        = 1'b1;
        stall           = 1'b1;
        redirect_target = 32'h0000_0013;
        step();
        check_if("t4.redir", 32'h10, 32'h0, 32'd0, 1'b0, 1'b0);
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        check_if("t4.fetch", 32'h14, 32'h2400_0010, 32'h14, 1'b1, 1'b0);

        // T5: run to end of memory and halt
        for (int i = 0; i < 40 && pc != 32'd112; i++) step();
        check("t5.reach112", pc, 32'd112);
        step();
        check_if("t5.last", 32'd116, 32'h2400_0070, 32'd116, 1'b1, 1'b0);
        step();
        check_if("t5.halt", 32'd116, 32'h0, 32'd0, 1'b0, 1'b1);
        step();
        check_if("t5.hold", 32'd116, 32'h0, 32'd0, 1'b0, 1'b1);
        redirect        = 1'b1;
        redirect_target = 32'h0000_0000;
        step();
        check_if("t5.redir", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
        redirect = 1'b0;
        step();
        check_if("t5.resume", 32'd4, 32'h2001_0005, 32'd4, 1'b1, 1'b0);

        // T6a: reset during stall
        stall = 1'b1;
        reset = 1'b0;
        step();
        check_if("t6.stall", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        stall = 1'b0;

        // T6b: reset during halt
        redirect        = 1'b1;
        redirect_target = 32'h0000_0070;
        step();
        redirect = 1'b0;
        step();
        check("t6.pc116", pc, 32'd116);
        step();
        check("t6.halted", {31'd0, halted}, 32'd1);
        reset = 1'b0;
        step();
        check_if("t6.halt", 32'd0, 32'h0, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_if("t6.after", 32'd4, 32'h2001_0005, 32'd4, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
